// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Snoops 68000 word/byte writes that land in a framebuffer window,
//            queues them, and interleaves them as byte writes to an 8-bit VRAM
//            between video read fetches. Video reads always win arbitration.
//            A write sequence (setup / strobe / hold) is never aborted.
// Ports    : pixClk             - single system clock (pixel clock)
//            nReset             - asynchronous active-low reset
//            cpuAddr/cpuData    - 68000 address (word) and data, async snoop
//            ncpuAS/UDS/LDS     - 68000 strobes, async snoop, active low
//            cpuRnW             - 68000 read/not-write, async snoop
//            vidReq/vidAddr     - video fetch request and byte address
//            vidGrant           - high while the VRAM bus performs the read
//            vramAddr/vramDout  - VRAM byte address and write data
//            vramDoe            - write-data drive enable
//            nvramOE/nvramWE    - VRAM output / write enables, active low
//            fifoEmpty          - write queue empty
//            overflow           - sticky: a write was dropped on a full queue
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter logic [23:0] FB_BASE    = 24'h3FA700,
    parameter int          FB_BYTES   = 8192,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        pixClk,
    input  logic        nReset,
    input  logic [23:1] cpuAddr,
    input  logic [15:0] cpuData,
    input  logic        ncpuAS,
    input  logic        ncpuUDS,
    input  logic        ncpuLDS,
    input  logic        cpuRnW,
    input  logic        vidReq,
    input  logic [12:0] vidAddr,
    output logic        vidGrant,
    output logic [12:0] vramAddr,
    output logic [7:0]  vramDout,
    output logic        vramDoe,
    output logic        nvramOE,
    output logic        nvramWE,
    output logic        fifoEmpty,
    output logic        overflow
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENT_W = 30;  // {wordOff[11:0], data[15:0], umask, lmask}

    // Window bounds carried in 25 bits so FB_BASE+FB_BYTES cannot wrap.
    localparam logic [24:0]        c_WIN_LO   = {1'b0, FB_BASE};
    localparam logic [24:0]        c_WIN_HI   = {1'b0, FB_BASE} + 25'(FB_BYTES);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_VREAD   = 3'd1,
        ST_WSETUP  = 3'd2,
        ST_WSTROBE = 3'd3,
        ST_WHOLD   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Bus strobe synchronizers, bit order {AS, UDS, LDS, RnW}; idle high
    // ------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= {ncpuAS, ncpuUDS, ncpuLDS, cpuRnW};
            r_sync2 <= r_sync1;
        end
    end

    logic w_asS, w_udsS, w_ldsS, w_rnwS;
    assign {w_asS, w_udsS, w_ldsS, w_rnwS} = r_sync2;

    // ------------------------------------------------------------------
    // Capture and window check
    // ------------------------------------------------------------------
    logic                r_armed;
    logic                w_capture;
    logic [23:0]         w_byteAddr;
    logic                w_inWindow;
    logic [11:0]         w_wordOff;
    logic [c_ENT_W-1:0]  w_pushEntry;

    // Address and data are sampled raw: by the time the synchronized data
    // strobe is seen, the 68000 has held them stable for several clocks.
    assign w_capture  = r_armed & ~w_asS & ~w_rnwS & (~w_udsS | ~w_ldsS);
    assign w_byteAddr = {cpuAddr, 1'b0};
    assign w_inWindow = ({1'b0, w_byteAddr} >= c_WIN_LO) &&
                        ({1'b0, w_byteAddr} <  c_WIN_HI);
    // Only narrowed once the address is known to be inside the window, so
    // out-of-window addresses can never alias onto a valid offset.
    assign w_wordOff  = w_inWindow ? 12'((w_byteAddr - FB_BASE) >> 1) : 12'd0;
    assign w_pushEntry = {w_wordOff, cpuData, ~w_udsS, ~w_ldsS};

    // ------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_fifoMem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_push;
    logic               w_pushOk;
    logic               w_pop;

    assign w_full   = (r_count == c_CNT_FULL);
    assign w_push   = w_capture & w_inWindow;
    // A pop in the same cycle frees a slot, so a push on full still lands.
    assign w_pushOk = w_push & (~w_full | w_pop);

    always_ff @(posedge pixClk) begin
        if (w_pushOk) begin
            r_fifoMem[r_wrPtr] <= w_pushEntry;
        end
    end

    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b1;
        end else begin
            if (w_capture) begin
                r_armed <= 1'b0;
            end else if (w_asS) begin
                r_armed <= 1'b1;
            end
            if (w_push && !w_pushOk) begin
                r_overflow <= 1'b1;
            end
            if (w_pushOk) begin
                r_wrPtr <= (r_wrPtr == c_PTR_LAST) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == c_PTR_LAST) ? '0 : r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry fields; stable for the whole write since popping happens
    // only in the hold phase of the entry's last byte.
    logic [c_ENT_W-1:0] w_head;
    logic [11:0]        w_headOff;
    logic [15:0]        w_headData;
    logic               w_headU;
    logic               w_headL;

    assign w_head     = r_fifoMem[r_rdPtr];
    assign w_headOff  = w_head[29:18];
    assign w_headData = w_head[17:2];
    assign w_headU    = w_head[1];
    assign w_headL    = w_head[0];

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_nextState;
    logic   r_byteSel;    // byte being written: 0 = upper, 1 = lower
    logic   r_upperDone;  // upper byte of head entry already written
    logic   w_selNext;
    logic   w_lastByte;

    assign w_selNext  = ~(w_headU & ~r_upperDone);
    assign w_lastByte = r_byteSel | ~w_headL;
    assign w_pop      = (r_state == ST_WHOLD) & w_lastByte;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (vidReq) begin
                    w_nextState = ST_VREAD;
                end else if (r_count != '0) begin
                    w_nextState = ST_WSETUP;
                end
            end
            ST_VREAD: begin
                if (!vidReq) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_WSETUP:  w_nextState = ST_WSTROBE;
            ST_WSTROBE: w_nextState = ST_WHOLD;
            ST_WHOLD:   w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so that every VRAM pin
    // changes cleanly on a clock edge, and doe/OE switch only via IDLE.
    logic [12:0] r_vramAddr;
    logic [7:0]  r_vramDout;
    logic        r_vramDoe;
    logic        r_nvramOE;
    logic        r_nvramWE;
    logic        r_vidGrant;

    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= ST_IDLE;
            r_byteSel   <= 1'b0;
            r_upperDone <= 1'b0;
            r_vramAddr  <= 13'd0;
            r_vramDout  <= 8'd0;
            r_vramDoe   <= 1'b0;
            r_nvramOE   <= 1'b1;
            r_nvramWE   <= 1'b1;
            r_vidGrant  <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (r_state == ST_WHOLD) begin
                r_upperDone <= ~w_lastByte;
            end

            case (w_nextState)
                ST_VREAD: begin
                    r_vramAddr <= vidAddr;
                    r_vramDoe  <= 1'b0;
                    r_nvramOE  <= 1'b0;
                    r_nvramWE  <= 1'b1;
                    r_vidGrant <= 1'b1;
                end
                ST_WSETUP: begin
                    r_byteSel  <= w_selNext;
                    r_vramAddr <= {w_headOff, w_selNext};
                    r_vramDout <= w_selNext ? w_headData[7:0] : w_headData[15:8];
                    r_vramDoe  <= 1'b1;
                    r_nvramOE  <= 1'b1;
                    r_nvramWE  <= 1'b1;
                    r_vidGrant <= 1'b0;
                end
                ST_WSTROBE: begin
                    r_vramDoe  <= 1'b1;
                    r_nvramOE  <= 1'b1;
                    r_nvramWE  <= 1'b0;
                    r_vidGrant <= 1'b0;
                end
                ST_WHOLD: begin
                    r_vramDoe  <= 1'b1;
                    r_nvramOE  <= 1'b1;
                    r_nvramWE  <= 1'b1;
                    r_vidGrant <= 1'b0;
                end
                default: begin
                    r_vramDoe  <= 1'b0;
                    r_nvramOE  <= 1'b1;
                    r_nvramWE  <= 1'b1;
                    r_vidGrant <= 1'b0;
                end
            endcase
        end
    end

    assign vramAddr  = r_vramAddr;
    assign vramDout  = r_vramDout;
    assign vramDoe   = r_vramDoe;
    assign nvramOE   = r_nvramOE;
    assign nvramWE   = r_nvramWE;
    assign vidGrant  = r_vidGrant;
    assign fifoEmpty = (r_count == '0);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Directed self-checking bench for vram_arbiter. Drives 68000
//            write cycles and video requests, logs every VRAM write strobe,
//            and compares against hand-computed byte writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic        pixClk;
    logic        nReset;
    logic [23:1] cpuAddr;
    logic [15:0] cpuData;
    logic        ncpuAS;
    logic        ncpuUDS;
    logic        ncpuLDS;
    logic        cpuRnW;
    logic        vidReq;
    logic [12:0] vidAddr;
    logic        vidGrant;
    logic [12:0] vramAddr;
    logic [7:0]  vramDout;
    logic        vramDoe;
    logic        nvramOE;
    logic        nvramWE;
    logic        fifoEmpty;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [12:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];
    int          weLen = 0;
    int          grantWait;

    vram_arbiter dut (
        .pixClk    (pixClk),
        .nReset    (nReset),
        .cpuAddr   (cpuAddr),
        .cpuData   (cpuData),
        .ncpuAS    (ncpuAS),
        .ncpuUDS   (ncpuUDS),
        .ncpuLDS   (ncpuLDS),
        .cpuRnW    (cpuRnW),
        .vidReq    (vidReq),
        .vidAddr   (vidAddr),
        .vidGrant  (vidGrant),
        .vramAddr  (vramAddr),
        .vramDout  (vramDout),
        .vramDoe   (vramDoe),
        .nvramOE   (nvramOE),
        .nvramWE   (nvramWE),
        .fifoEmpty (fifoEmpty),
        .overflow  (overflow)
    );

    initial pixClk = 1'b0;
    always #20 pixClk = ~pixClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] logAddr(input int i);
        return (i < wrAddrQ.size()) ? wrAddrQ[i] : 13'hxxxx;
    endfunction

    function automatic logic [7:0] logData(input int i);
        return (i < wrDataQ.size()) ? wrDataQ[i] : 8'hxx;
    endfunction

    task automatic clearLog();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge pixClk);
    endtask

    // One 68000 write bus cycle; u/l = 1 means that data strobe is asserted.
    task automatic busWrite(input logic [22:0] a, input logic [15:0] d,
                            input logic u, input logic l);
        @(negedge pixClk);
        cpuAddr = a;
        cpuData = d;
        cpuRnW  = 1'b0;
        ncpuAS  = 1'b0;
        cycles(2);
        ncpuUDS = ~u;
        ncpuLDS = ~l;
        cycles(4);
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
        ncpuAS  = 1'b1;
        cpuRnW  = 1'b1;
        cycles(3);
    endtask

    // Write-strobe logger plus bus contention check, sampled mid-cycle.
    always @(negedge pixClk) begin
        if (nReset === 1'b1) begin
            chk("doe_oe_exclusive", {31'd0, vramDoe & ~nvramOE}, 32'd0);
            if (nvramWE === 1'b0) begin
                if (weLen == 0) begin
                    wrAddrQ.push_back(vramAddr);
                    wrDataQ.push_back(vramDout);
                end
                weLen++;
            end else if (weLen != 0) begin
                chk("we_pulse_len", weLen, 32'd1);
                weLen = 0;
            end
        end
    end

    initial begin
        nReset  = 1'b0;
        cpuAddr = '0;
        cpuData = '0;
        ncpuAS  = 1'b1;
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
        cpuRnW  = 1'b1;
        vidReq  = 1'b0;
        vidAddr = '0;

        // Reset state
        cycles(2);
        chk("rst_fifoEmpty", fifoEmpty, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_nvramWE", nvramWE, 1);
        chk("rst_nvramOE", nvramOE, 1);
        chk("rst_vramDoe", vramDoe, 0);
        chk("rst_vidGrant", vidGrant, 0);
        chk("rst_vramAddr", vramAddr, 0);
        chk("rst_vramDout", vramDout, 0);
        nReset = 1'b1;
        cycles(2);

        // Word write at the window base: upper byte then lower byte
        clearLog();
        busWrite(23'h1FD380, 16'hA55A, 1'b1, 1'b1);
        cycles(12);
        chk("word_count", wrAddrQ.size(), 2);
        chk("word_addr0", logAddr(0), 13'h000);
        chk("word_data0", logData(0), 8'hA5);
        chk("word_addr1", logAddr(1), 13'h001);
        chk("word_data1", logData(1), 8'h5A);
        chk("word_fifoEmpty", fifoEmpty, 1);

        // LDS-only write: single lower byte
        clearLog();
        busWrite(23'h1FD3FF, 16'h00C3, 1'b0, 1'b1);
        cycles(12);
        chk("lds_count", wrAddrQ.size(), 1);
        chk("lds_addr", logAddr(0), 13'h0FF);
        chk("lds_data", logData(0), 8'hC3);

        // Just below the window and exactly at its end: ignored, no flag
        clearLog();
        busWrite(23'h1FD37F, 16'h1111, 1'b1, 1'b1);
        busWrite(23'h1FE380, 16'h2222, 1'b1, 1'b1);
        cycles(12);
        chk("oow_count", wrAddrQ.size(), 0);
        chk("oow_overflow", overflow, 0);
        chk("oow_fifoEmpty", fifoEmpty, 1);

        // Last word inside the window
        clearLog();
        busWrite(23'h1FE37F, 16'h6789, 1'b1, 1'b1);
        cycles(12);
        chk("top_count", wrAddrQ.size(), 2);
        chk("top_addr0", logAddr(0), 13'h1FFE);
        chk("top_data0", logData(0), 8'h67);
        chk("top_addr1", logAddr(1), 13'h1FFF);
        chk("top_data1", logData(1), 8'h89);

        // Video holds the bus: queued writes wait, then drain
        clearLog();
        vidAddr = 13'h123;
        vidReq  = 1'b1;
        cycles(3);
        chk("vr_grant", vidGrant, 1);
        chk("vr_nvramOE", nvramOE, 0);
        chk("vr_vramDoe", vramDoe, 0);
        chk("vr_vramAddr", vramAddr, 13'h123);
        busWrite(23'h1FD390, 16'h1234, 1'b1, 1'b0);
        busWrite(23'h1FD391, 16'hBEEF, 1'b1, 1'b1);
        cycles(6);
        chk("vr_hold_count", wrAddrQ.size(), 0);
        chk("vr_hold_fifoEmpty", fifoEmpty, 0);
        chk("vr_hold_grant", vidGrant, 1);
        vidReq = 1'b0;
        cycles(20);
        chk("drain_count", wrAddrQ.size(), 3);
        chk("drain_addr0", logAddr(0), 13'h020);
        chk("drain_data0", logData(0), 8'h12);
        chk("drain_addr1", logAddr(1), 13'h022);
        chk("drain_data1", logData(1), 8'hBE);
        chk("drain_addr2", logAddr(2), 13'h023);
        chk("drain_data2", logData(2), 8'hEF);
        chk("drain_fifoEmpty", fifoEmpty, 1);
        chk("drain_grant", vidGrant, 0);
        chk("drain_nvramOE", nvramOE, 1);

        // Video request raised during the write strobe
        clearLog();
        grantWait = -1;
        fork
            busWrite(23'h1FD3A0, 16'h7788, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge pixClk);
                    if (nvramWE === 1'b0) begin
                        vidReq = 1'b1;
                        break;
                    end
                end
                if (vidReq) begin
                    for (int k = 1; k <= 6; k++) begin
                        @(negedge pixClk);
                        if (vidGrant === 1'b1 && grantWait < 0) grantWait = k;
                    end
                end
            end
        join
        chk("grant_latency_ok", {31'd0, (grantWait >= 1 && grantWait <= 4)}, 32'd1);
        chk("split_count", wrAddrQ.size(), 1);
        chk("split_addr0", logAddr(0), 13'h040);
        chk("split_data0", logData(0), 8'h77);
        chk("split_fifoEmpty", fifoEmpty, 0);
        vidReq = 1'b0;
        cycles(12);
        chk("split_count2", wrAddrQ.size(), 2);
        chk("split_addr1", logAddr(1), 13'h041);
        chk("split_data1", logData(1), 8'h88);
        chk("split_fifoEmpty2", fifoEmpty, 1);

        // Fill the queue under video priority, then overflow it
        clearLog();
        vidReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            busWrite(23'(23'h1FD380 + i), 16'(16'h1000 + i), 1'b1, 1'b1);
        end
        chk("full_overflow", overflow, 0);
        chk("full_fifoEmpty", fifoEmpty, 0);
        busWrite(23'h1FD390, 16'h5555, 1'b1, 1'b1);
        chk("ovf_overflow", overflow, 1);
        chk("ovf_count", wrAddrQ.size(), 0);

        // Asynchronous reset pulse clears everything, no entry survives
        @(negedge pixClk);
        nReset = 1'b0;
        #2;
        chk("arst_overflow", overflow, 0);
        chk("arst_fifoEmpty", fifoEmpty, 1);
        chk("arst_nvramWE", nvramWE, 1);
        chk("arst_nvramOE", nvramOE, 1);
        chk("arst_vidGrant", vidGrant, 0);
        cycles(2);
        weLen  = 0;
        vidReq = 1'b0;
        nReset = 1'b1;
        cycles(15);
        chk("post_rst_count", wrAddrQ.size(), 0);
        chk("post_rst_fifoEmpty", fifoEmpty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FB_BASE, default 24'h3FA700, meaning the 68000 byte address of the first byte of the captured framebuffer window.
REQ-002 SHALL have parameter FB_BYTES, default 8192, meaning the window length in bytes; byte offsets are 13 bits wide.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued CPU word-write entries.
REQ-004 Ports: pixClk  in  1  single 25.175MHz clock; all logic runs on this clock.
REQ-005 Ports: nReset  in  1  asynchronous, active-low reset.
REQ-006 Ports: cpuAddr[23:1] in 23, cpuData[15:0] in 16, ncpuAS in 1, ncpuUDS in 1, ncpuLDS in 1, cpuRnW in 1; all are asynchronous 68000 bus snoop inputs.
REQ-007 Ports: vidReq  in  1  video fetch request; vidAddr[12:0]  in  13  video fetch byte address.
REQ-008 Ports: vidGrant  out  1  high while the VRAM bus is performing the video read.
REQ-009 Ports: vramAddr[12:0] out 13, vramDout[7:0] out 8, vramDoe out 1 (data drive enable), nvramOE out 1, nvramWE out 1.
REQ-010 Ports: fifoEmpty  out  1  queue empty; overflow  out  1  sticky flag, set when a write is dropped.

Function
REQ-011 ncpuAS, ncpuUDS, ncpuLDS and cpuRnW SHALL each pass through a 2-flop synchronizer before use.
REQ-012 Capture condition: synchronized AS low, synchronized RnW low, and the first cycle in which either synchronized DS is low; cpuAddr and cpuData are sampled in that cycle.
REQ-013 After a capture, the capture logic SHALL be disarmed until synchronized AS returns high; the result is exactly one capture per bus cycle.
REQ-014 Byte address = {cpuAddr,1'b0}. The write SHALL be accepted only if FB_BASE <= byte address < FB_BASE+FB_BYTES; otherwise it is ignored with no flag.
REQ-015 An accepted write SHALL push one entry: word offset [12:1], data[15:0], umask (UDS low), lmask (LDS low).
REQ-016 Push when full SHALL drop the entry and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-017 FSM states: IDLE, VREAD, WSETUP, WSTROBE, WHOLD.
REQ-018 IDLE: if vidReq is high, go to VREAD (video has priority); else if the queue is non-empty, go to WSETUP; else stay in IDLE.
REQ-019 VREAD: vramAddr=vidAddr, nvramOE=0, vidGrant=1, vramDoe=0. Stay while vidReq is high; return to IDLE when vidReq is low.
REQ-020 WSETUP: vramAddr={offset,byteSel}, vramDout=selected byte, vramDoe=1, nvramOE=1, nvramWE=1.
REQ-021 WSTROBE: same address and data as WSETUP, with nvramWE=0.
REQ-022 WHOLD: nvramWE=1 with address and data held. The next state is always IDLE, so a write sequence is never aborted.
REQ-023 Byte order within an entry: upper byte (byteSel=0, data[15:8]) first if umask is set, then lower byte (byteSel=1, data[7:0]) if lmask is set. Arbitration SHALL be re-run in IDLE between the two bytes.
REQ-024 The entry SHALL be popped in the WHOLD of its last enabled byte.
REQ-025 vidReq asserted during WSETUP/WSTROBE/WHOLD SHALL be granted within 4 cycles. The video fetch issues vidReq at least 4 cycles before its data is needed.
REQ-026 Outside VREAD, nvramOE SHALL be 1. vramDoe and nvramOE SHALL never both be active in the same cycle.
REQ-027 Offset arithmetic (byte address − FB_BASE) SHALL be truncated to 13 bits only after the window check passes.

Reset
REQ-028 nReset low SHALL asynchronously force: FSM=IDLE, queue empty (fifoEmpty=1), overflow=0, capture armed, synchronizers=idle-high, vramAddr=0, vramDout=0, vramDoe=0, nvramOE=1, nvramWE=1, vidGrant=0.
REQ-029 Reset asserted mid-write SHALL abandon the write immediately; no pending entry survives reset.
REQ-030 Outputs SHALL leave reset values only on the first pixClk edge after nReset is deasserted.

Verification
REQ-031 Word write cpuAddr=23'h1FD380, data 16'hA55A, both strobes low -> VRAM byte 0x000=8'hA5, then 0x001=8'h5A; each with nvramWE low for exactly 1 cycle; fifoEmpty then returns to 1.
REQ-032 LDS-only write to byte address 0x3FA7FF (cpuAddr=23'h1FD3FF), data 16'h00C3 -> one write, vramAddr=13'h0FF, data 8'hC3.
REQ-033 Write to 0x3FA6FE, and a write to FB_BASE+8192 -> no VRAM write, overflow stays 0.
REQ-034 vidReq held high while 2 entries are queued -> no write starts; once vidReq drops, writes drain. vidReq re-raised during WSTROBE -> vidGrant high within 4 cycles.
REQ-035 Five accepted writes with vidReq held high -> four queued, overflow=1. Then nReset pulse -> overflow=0, fifoEmpty=1, nvramWE=1.
